serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell adds two N-bit operands LSB first.
// Optional macro ADD_SUB_EN adds a sub port selecting a + ~b + 1 at start.

module summ (
  input  logic pi,
  input  logic a,
  input  logic b,
  output logic r,
  output logic p0
);
  assign r  = a ^ b ^ pi;
  assign p0 = (a & b) | (a & pi) | (b & pi);
endmodule

module serial_add_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] A,
`ifdef ADD_SUB_EN
  input  logic           sub,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] sum,
  output logic [1:0]     dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Handshake: start is a level request sampled only in IDLE; busy covers
  // the whole operation and done pulses for exactly one cycle per result.
  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    work_q, work_d;
  logic [N:0]      res_q, res_d;
  logic            r_w, p0_w;
  logic            sub_w;
  logic [2*N-1:0]  res_ext;

`ifdef ADD_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  summ u_summ (
    .pi (carry_q),
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .r  (r_w),
    .p0 (p0_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    work_d  = work_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A[N-1:0];
          // Subtraction folds into addition: invert b once here, carry-in 1.
          b_d     = sub_w ? ~A[2*N-1:N] : A[2*N-1:N];
          carry_d = sub_w;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[idx_q] = r_w;
        carry_d       = p0_w;
        if (idx_q == IW'(N - 1)) begin
          res_d   = {p0_w, work_d};
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    res_ext        = '0;
    res_ext[N:0]   = res_q;
  end

  assign sum       = ~res_ext;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (N=4); sub tests compile only with ADD_SUB_EN.

module tb_serial_add_ctrl;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] A;
  logic           sub;
  logic           busy;
  logic           done;
  logic [2*N-1:0] sum;
  logic [1:0]     dbg_state;

  int n_checks;
  int n_fail;

  serial_add_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
`ifdef ADD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held for a few cycles; outputs must already be at reset values.
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    sub   = 1'b0;
    #2;
    n_checks++;
    if (sum !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: sum=%h busy=%b done=%b, required sum=ff busy=0 done=0", sum, busy, done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sum !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: sum=%h busy=%b done=%b state=%0d, required ff/0/0/0", sum, busy, done, dbg_state);
    end
  endtask

  // Start issued together with reset release: accepted at the first rising edge.
  task automatic test_zero();
    rst_n = 1'b1;
    A     = 8'h00;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      n_checks++;
      if (busy !== (i < 5) || done !== (i == 4) || sum !== 8'hFF) begin
        n_fail++;
        $display("FAIL zero_op cyc%0d: busy=%b done=%b sum=%h, required busy=%b done=%b sum=ff",
                 i, busy, done, sum, (i < 5), (i == 4));
      end
    end
  endtask

  // One operation with full timing check; sum must hold old_sum until publish.
  task automatic run_add(input logic [7:0] a_in, input logic sub_in,
                         input logic [7:0] old_sum, input logic [7:0] exp_sum, input string name);
    @(negedge clk);
    A     = a_in;
    sub   = sub_in;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      n_checks++;
      if (busy !== (i < 5) || done !== (i == 4) || sum !== ((i < 4) ? old_sum : exp_sum)) begin
        n_fail++;
        $display("FAIL %s cyc%0d: busy=%b done=%b sum=%h, required busy=%b done=%b sum=%h",
                 name, i, busy, done, sum, (i < 5), (i == 4), ((i < 4) ? old_sum : exp_sum));
      end
    end
  endtask

  task automatic test_add_vectors();
    run_add(8'hFF, 1'b0, 8'hFF, 8'hE1, "add_ff");
    run_add(8'h53, 1'b0, 8'hE1, 8'hF7, "add_53");
    run_add(8'h0F, 1'b0, 8'hF7, 8'hF0, "add_0f");
    run_add(8'h88, 1'b0, 8'hF0, 8'hEF, "add_88");
    run_add(8'h21, 1'b0, 8'hEF, 8'hFC, "add_21");
  endtask

`ifdef ADD_SUB_EN
  task automatic test_sub();
    run_add(8'h53, 1'b1, 8'hFC, 8'hF1, "sub_53");
    run_add(8'h35, 1'b1, 8'hF1, 8'hED, "sub_35");
    run_add(8'h35, 1'b0, 8'hED, 8'hF7, "add_after_sub");
  endtask
`endif

  // Second start (with new A) during RUN must be ignored.
  task automatic test_ignore_start();
    int dones;
    dones = 0;
    @(negedge clk);
    A     = 8'h97;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 1) begin
        start = 1'b1;
        A     = 8'h11;
      end
      if (i == 2) start = 1'b0;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d, required 1", dones);
    end
    n_checks++;
    if (sum !== 8'hEF) begin
      n_fail++;
      $display("FAIL ignore_sum: got %h, required ef", sum);
    end
  endtask

  // Reset in the middle of RUN: immediate abort, no publish, no later done.
  task automatic test_reset_abort();
    int dones;
    dones = 0;
    @(negedge clk);
    A     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'hFF || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_immediate: busy=%b done=%b sum=%h state=%0d, required 0/0/ff/0",
               busy, done, sum, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0 || sum !== 8'hFF) begin
      n_fail++;
      $display("FAIL abort_after: active cycles=%0d sum=%h, required 0 and ff", dones, sum);
    end
  endtask

  // start held high: one result every N+2 cycles.
  task automatic test_back_to_back();
    int dones;
    int last;
    dones = 0;
    last  = -1;
    @(negedge clk);
    A     = 8'h21;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        n_checks++;
        if (sum !== 8'hFC || (last >= 0 && i - last != N + 2) || (last < 0 && i != N)) begin
          n_fail++;
          $display("FAIL b2b_done cyc%0d: sum=%h gap=%0d, required sum=fc gap=%0d", i, sum, i - last, N + 2);
        end
        last = i;
      end
    end
    start = 1'b0;
    n_checks++;
    if (dones !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d, required 3", dones);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || sum !== 8'hFC) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b sum=%h, required 0 and fc", busy, sum);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero();
    test_add_vectors();
`ifdef ADD_SUB_EN
    test_sub();
`endif
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
